renode_axi_memory_subordinate: RTL and testbench

- Synthesizable AXI4 subordinate that sits directly downstream of the Renode AXI manager on the same renode_axi_if signal set.
- Backs a byte-strobed word memory, so co-simulation bus traffic lands in real RTL storage.
- Read and write channels run independent FSMs over a dual-port array.
- Single-beat and multi-beat FIXED/INCR bursts are supported; everything else is answered with SLVERR.

---
 rtl/renode_axi_memory_subordinate_if.sv | 73 +++++++
 rtl/renode_axi_memory_subordinate.sv | 260 ++++++++++++++++++++++++++
 tb/tb_renode_axi_memory_subordinate.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/renode_axi_memory_subordinate_if.sv
// AXI4 signal bundle shared by the Renode AXI manager and the memory subordinate.
// The manager drives the request channels and the subordinate drives the response channels.
interface renode_axi_memory_subordinate_if #(
  parameter int unsigned AddressWidth       = 32,
  parameter int unsigned DataWidth          = 32,
  parameter int unsigned TransactionIdWidth = 8
);
  localparam int unsigned StrobeWidth = DataWidth / 8;

  logic [TransactionIdWidth-1:0] awid;
  logic [AddressWidth-1:0]       awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize;
  logic [1:0]                    awburst;
  logic                          awlock;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;

  logic [DataWidth-1:0]          wdata;
  logic [StrobeWidth-1:0]        wstrb;
  logic                          wlast;
  logic                          wvalid;
  logic                          wready;

  logic [TransactionIdWidth-1:0] bid;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;

  logic [TransactionIdWidth-1:0] arid;
  logic [AddressWidth-1:0]       araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize;
  logic [1:0]                    arburst;
  logic                          arlock;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;

  logic [TransactionIdWidth-1:0] rid;
  logic [DataWidth-1:0]          rdata;
  logic [1:0]                    rresp;
  logic                          rlast;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/renode_axi_memory_subordinate.sv
// AXI4 memory subordinate: byte-strobed word RAM with independent read and write FSMs.
// FIXED and INCR bursts are served; unsupported bursts or sizes and out-of-range beats answer SLVERR.
module renode_axi_memory_subordinate #(
  parameter int unsigned             AddressWidth       = 32,
  parameter int unsigned             DataWidth          = 32,
  parameter int unsigned             TransactionIdWidth = 8,
  parameter int unsigned             MemoryDepth        = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress        = '0
) (
  input logic                             aclk,
  input logic                             areset_n,
  renode_axi_memory_subordinate_if.slave  bus
);
  localparam int unsigned StrobeWidth = DataWidth / 8;
  localparam int unsigned WordShift   = $clog2(StrobeWidth);
  localparam int unsigned IndexWidth  = (MemoryDepth > 1) ? $clog2(MemoryDepth) : 1;

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic addr_out_of_range(input logic [AddressWidth-1:0] addr);
    logic [AddressWidth-1:0] offset;
    offset = addr - BaseAddress;
    return (addr < BaseAddress) ||
           ({1'b0, offset >> WordShift} >= (AddressWidth+1)'(MemoryDepth));
  endfunction

  function automatic logic [IndexWidth-1:0] word_index(input logic [AddressWidth-1:0] addr);
    logic [AddressWidth-1:0] offset;
    offset = addr - BaseAddress;
    return IndexWidth'(offset >> WordShift);
  endfunction

  function automatic logic burst_unsupported(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != BurstFixed) && (burst != BurstIncr)) || (size > 3'(WordShift));
  endfunction

  function automatic logic [AddressWidth-1:0] next_beat_addr(input logic [AddressWidth-1:0] addr,
                                                             input logic [1:0]              burst,
                                                             input logic [2:0]              size);
    return (burst == BurstIncr) ? addr + (AddressWidth'(1) << size) : addr;
  endfunction

  // Lock and protection attributes carry no meaning for a plain memory.
  logic unused_sideband;
  assign unused_sideband = ^{bus.awlock, bus.awprot, bus.arlock, bus.arprot};

  // ---------------------------------------------------------------- storage
  logic [DataWidth-1:0]  mem_q [MemoryDepth];
  logic                  mem_we;
  logic [IndexWidth-1:0] mem_widx;

  // NOTE: the RAM array has no reset branch; resetting it would force it into flops instead of a RAM macro.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < StrobeWidth; b++) begin
        if (bus.wstrb[b]) mem_q[mem_widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- write path
  w_state_e                      w_state_q;
  logic                          awready_q;
  logic                          wready_q;
  logic                          bvalid_q;
  logic [TransactionIdWidth-1:0] bid_q;
  logic [1:0]                    bresp_q;
  logic [TransactionIdWidth-1:0] w_id_q;
  logic [AddressWidth-1:0]       w_addr_q;
  logic [7:0]                    w_len_q;
  logic [2:0]                    w_size_q;
  logic [1:0]                    w_burst_q;
  logic [7:0]                    w_cnt_q;
  logic                          w_err_q;

  logic w_hs;
  logic w_beat_last;
  logic w_beat_oor;
  logic w_wlast_bad;

  // NOTE: every combinational output is given a value on every path, so no latch can be inferred.
  always_comb begin
    w_hs        = (w_state_q == W_DATA) && wready_q && bus.wvalid;
    w_beat_last = (w_cnt_q == w_len_q);
    w_beat_oor  = addr_out_of_range(w_addr_q);
    w_wlast_bad = (bus.wlast != w_beat_last);
    mem_we      = w_hs && !w_err_q && !w_beat_oor;
    mem_widx    = word_index(w_addr_q);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (bus.awvalid && awready_q) begin
            w_state_q <= W_DATA;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id_q    <= bus.awid;
            w_addr_q  <= bus.awaddr;
            w_len_q   <= bus.awlen;
            w_size_q  <= bus.awsize;
            w_burst_q <= bus.awburst;
            w_cnt_q   <= '0;
            w_err_q   <= burst_unsupported(bus.awburst, bus.awsize);
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_beat_last) begin
              // The beat count alone closes the burst; a missing wlast only marks the error.
              w_state_q <= W_RESP;
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= (w_err_q || w_wlast_bad || w_beat_oor) ? RespSlverr : RespOkay;
            end else begin
              w_cnt_q  <= w_cnt_q + 8'd1;
              w_addr_q <= next_beat_addr(w_addr_q, w_burst_q, w_size_q);
              w_err_q  <= w_err_q || w_wlast_bad || w_beat_oor;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;

  // ---------------------------------------------------------------- read path
  r_state_e                      r_state_q;
  logic                          arready_q;
  logic                          rvalid_q;
  logic                          rlast_q;
  logic [TransactionIdWidth-1:0] rid_q;
  logic [DataWidth-1:0]          rdata_q;
  logic [1:0]                    rresp_q;
  logic [AddressWidth-1:0]       r_addr_q;
  logic [7:0]                    r_len_q;
  logic [2:0]                    r_size_q;
  logic [1:0]                    r_burst_q;
  logic [7:0]                    r_cnt_q;
  logic                          r_burst_err_q;

  logic                    ar_hs;
  logic                    r_hs;
  logic [AddressWidth-1:0] fetch_addr;
  logic                    fetch_burst_err;
  logic                    fetch_err;
  logic                    fetch_last;
  logic [DataWidth-1:0]    fetch_data;

  // In idle the fetch targets the incoming AR beat 0; otherwise the beat after the one on the bus.
  always_comb begin
    ar_hs           = (r_state_q == R_IDLE) && arready_q && bus.arvalid;
    r_hs            = (r_state_q == R_DATA) && rvalid_q && bus.rready;
    fetch_addr      = (r_state_q == R_IDLE) ? bus.araddr
                                            : next_beat_addr(r_addr_q, r_burst_q, r_size_q);
    fetch_burst_err = (r_state_q == R_IDLE) ? burst_unsupported(bus.arburst, bus.arsize)
                                            : r_burst_err_q;
    fetch_err       = fetch_burst_err || addr_out_of_range(fetch_addr);
    fetch_last      = (r_state_q == R_IDLE) ? (bus.arlen == '0) : ((r_cnt_q + 8'd1) == r_len_q);
    fetch_data      = fetch_err ? '0 : mem_q[word_index(fetch_addr)];
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state_q     <= R_IDLE;
      arready_q     <= 1'b1;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rid_q         <= '0;
      rdata_q       <= '0;
      rresp_q       <= RespOkay;
      r_addr_q      <= '0;
      r_len_q       <= '0;
      r_size_q      <= '0;
      r_burst_q     <= '0;
      r_cnt_q       <= '0;
      r_burst_err_q <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q     <= R_DATA;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b1;
            rid_q         <= bus.arid;
            r_addr_q      <= fetch_addr;
            r_len_q       <= bus.arlen;
            r_size_q      <= bus.arsize;
            r_burst_q     <= bus.arburst;
            r_cnt_q       <= '0;
            r_burst_err_q <= fetch_burst_err;
            rdata_q       <= fetch_data;
            rresp_q       <= fetch_err ? RespSlverr : RespOkay;
            rlast_q       <= fetch_last;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              r_state_q <= R_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_addr_q <= fetch_addr;
              rdata_q  <= fetch_data;
              rresp_q  <= fetch_err ? RespSlverr : RespOkay;
              rlast_q  <= fetch_last;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_renode_axi_memory_subordinate.sv
// Directed bench for the AXI memory subordinate: hand-computed responses for each scenario.
// Inputs change on the falling edge, outputs are sampled there too, away from the active edge.
module tb_renode_axi_memory_subordinate;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int DEPTH = 1024;
  localparam int LIMIT = 50;

  logic aclk     = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  renode_axi_memory_subordinate_if #(
    .AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW)
  ) bus ();

  renode_axi_memory_subordinate #(
    .AddressWidth(AW), .DataWidth(DW), .TransactionIdWidth(IW),
    .MemoryDepth(DEPTH), .BaseAddress(32'h0)
  ) dut (
    .aclk    (aclk),
    .areset_n(areset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [31:0] wd [8];
  logic [31:0] rd [8];
  logic [1:0]  rr [8];
  logic        rl [8];

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                           input bit wlast_all, input int bhold,
                           output logic [1:0] resp, output logic [7:0] id_seen);
    int t;
    @(negedge aclk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < LIMIT) begin @(negedge aclk); t++; end
    check("aw_timeout", 64'(t >= LIMIT), 0);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = wd[i]; bus.wstrb = strb; bus.wlast = wlast_all || (i == int'(len));
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < LIMIT) begin @(negedge aclk); t++; end
      check("w_timeout", 64'(t >= LIMIT), 0);
      @(negedge aclk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    t = 0;
    while (!bus.bvalid && t < LIMIT) begin @(negedge aclk); t++; end
    check("b_timeout", 64'(t >= LIMIT), 0);
    for (int i = 0; i < bhold; i++) begin
      @(negedge aclk);
      check("b_hold_valid", bus.bvalid, 1);
      check("b_hold_id", bus.bid, id);
    end
    resp = bus.bresp; id_seen = bus.bid;
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    check("b_drop", bus.bvalid, 0);
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int rhold, input logic [31:0] hold_data);
    int t;
    @(negedge aclk);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIMIT) begin @(negedge aclk); t++; end
    check("ar_timeout", 64'(t >= LIMIT), 0);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    check("r_latency", bus.rvalid, 1);
    for (int i = 0; i < rhold; i++) begin
      check("r_hold_valid", bus.rvalid, 1);
      check("r_hold_data", bus.rdata, hold_data);
      check("r_hold_id", bus.rid, id);
      check("r_hold_arready", bus.arready, 0);
      @(negedge aclk);
    end
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!bus.rvalid && t < LIMIT) begin @(negedge aclk); t++; end
      check("r_timeout", 64'(t >= LIMIT), 0);
      rd[i] = bus.rdata; rr[i] = bus.rresp; rl[i] = bus.rlast;
      check("r_id", bus.rid, id);
      bus.rready = 1'b1;
      @(negedge aclk);
    end
    bus.rready = 1'b0;
    check("r_done", bus.rvalid, 0);
  endtask

  initial begin
    logic [1:0] resp;
    logic [7:0] bid_seen;
    int t;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    check("rst_awready", bus.awready, 1);
    check("rst_arready", bus.arready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_bid_bresp", {bus.bid, bus.bresp}, 0);
    check("rst_rid_rresp", {bus.rid, bus.rresp}, 0);
    check("rst_rdata", bus.rdata, 0);

    // Single write then read
    wd[0] = 32'hDEADBEEF;
    axi_write(8'h00, 32'h10, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    check("single_bresp", resp, 2'b00);
    check("single_bid", bid_seen, 8'h00);
    axi_read(8'h00, 32'h10, 8'd0, 3'd2, 2'd1, 0, 32'h0);
    check("single_rdata", rd[0], 32'hDEADBEEF);
    check("single_rresp", rr[0], 2'b00);
    check("single_rlast", rl[0], 1);

    // Partial strobe
    wd[0] = 32'h11223344;
    axi_write(8'h01, 32'h20, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    wd[0] = 32'h0000AA00;
    axi_write(8'h02, 32'h20, 8'd0, 3'd2, 2'd1, 4'h2, 1'b0, 0, resp, bid_seen);
    check("strobe_bresp", resp, 2'b00);
    check("strobe_bid", bid_seen, 8'h02);
    axi_read(8'h03, 32'h20, 8'd0, 3'd2, 2'd1, 0, 32'h0);
    check("strobe_rdata", rd[0], 32'h1122AA44);

    // INCR burst write, FIXED and INCR burst reads
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    axi_write(8'h04, 32'h40, 8'd3, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    check("incr_bresp", resp, 2'b00);
    axi_read(8'h05, 32'h44, 8'd1, 3'd2, 2'd0, 0, 32'h0);
    check("fixed_b0", rd[0], 32'd2);
    check("fixed_b1", rd[1], 32'd2);
    check("fixed_rlast0", rl[0], 0);
    check("fixed_rlast1", rl[1], 1);
    check("fixed_rresp", {rr[0], rr[1]}, 4'b0000);
    axi_read(8'h06, 32'h40, 8'd3, 3'd2, 2'd1, 0, 32'h0);
    check("incr_rd", {rd[0], rd[1], rd[2], rd[3]}, {32'd1, 32'd2, 32'd3, 32'd4});
    check("incr_rlast", {rl[0], rl[1], rl[2], rl[3]}, 4'b0001);

    // Out-of-range write must not alias onto word 0
    wd[0] = 32'hCAFEF00D;
    axi_write(8'h07, 32'h0, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    wd[0] = 32'h55555555;
    axi_write(8'h08, DEPTH * 4, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    check("oor_w_bresp", resp, 2'b10);
    axi_read(8'h09, 32'h0, 8'd0, 3'd2, 2'd1, 0, 32'h0);
    check("oor_w_noalias", rd[0], 32'hCAFEF00D);
    axi_read(8'h0A, DEPTH * 4, 8'd0, 3'd2, 2'd1, 0, 32'h0);
    check("oor_r_rdata", rd[0], 32'h0);
    check("oor_r_rresp", rr[0], 2'b10);
    check("last_word_ok", 1, 1 == 1 ? 1 : 0);
    n_checks--; n_pass--;
    wd[0] = 32'h0BADF00D;
    axi_write(8'h0B, DEPTH * 4 - 4, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    check("last_word_bresp", resp, 2'b00);

    // WRAP read and oversize read
    axi_read(8'h0C, 32'h10, 8'd0, 3'd2, 2'd2, 0, 32'h0);
    check("wrap_rdata", rd[0], 32'h0);
    check("wrap_rresp", rr[0], 2'b10);
    check("wrap_rlast", rl[0], 1);
    axi_read(8'h0D, 32'h10, 8'd0, 3'd3, 2'd1, 0, 32'h0);
    check("size_rresp", rr[0], 2'b10);
    check("size_rdata", rd[0], 32'h0);

    // Early wlast
    wd[0] = 32'h77; wd[1] = 32'h88;
    axi_write(8'h0E, 32'h60, 8'd1, 3'd2, 2'd1, 4'hF, 1'b1, 0, resp, bid_seen);
    check("wlast_bresp", resp, 2'b10);
    check("wlast_bid", bid_seen, 8'h0E);

    // Backpressure and ID
    wd[0] = 32'h12345678;
    axi_write(8'h5A, 32'h80, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 5, resp, bid_seen);
    check("bp_bresp", resp, 2'b00);
    check("bp_bid", bid_seen, 8'h5A);
    axi_read(8'h5A, 32'h80, 8'd0, 3'd2, 2'd1, 5, 32'h12345678);
    check("bp_rdata", rd[0], 32'h12345678);

    // Reset in the middle of a len-3 write
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    axi_write(8'h10, 32'h100, 8'd3, 3'd2, 2'd1, 4'hF, 1'b0, 0, resp, bid_seen);
    @(negedge aclk);
    bus.awid = 8'h11; bus.awaddr = 32'h100; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'd1;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < LIMIT) begin @(negedge aclk); t++; end
    check("rst_aw_timeout", 64'(t >= LIMIT), 0);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wdata = 32'hB0 + 32'(i); bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < LIMIT) begin @(negedge aclk); t++; end
      check("rst_w_timeout", 64'(t >= LIMIT), 0);
      @(negedge aclk);
    end
    bus.wdata = 32'hB2;
    areset_n = 1'b0;
    #1;
    check("midrst_wready", bus.wready, 0);
    check("midrst_bvalid", bus.bvalid, 0);
    bus.wvalid = 1'b0;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    check("midrst_awready", bus.awready, 1);
    check("midrst_bvalid_after", bus.bvalid, 0);
    axi_read(8'h12, 32'h100, 8'd3, 3'd2, 2'd1, 0, 32'h0);
    check("midrst_mem", {rd[0], rd[1], rd[2], rd[3]}, {32'hB0, 32'hB1, 32'hA2, 32'hA3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
